// File: rtl/coin_pulse_conditioner.sv
// Coin sensor front end: synchronizes and debounces three coin channels and emits one-cycle coin pulses.
// It flags simultaneous coins and reports a jam when any channel stays high too long.
module coin_pulse_conditioner #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int JAM_CYCLES      = 1000
) (
   input  logic clk_in,
   input  logic reset,
   input  logic bir_raw,
   input  logic elli_raw,
   input  logic yirmibes_raw,
   output logic bir,
   output logic elli,
   output logic yirmibes,
   output logic multi_err,
   output logic jam
);

   localparam logic [15:0] DB_LAST  = 16'(DEBOUNCE_CYCLES - 1);
   localparam logic [19:0] JAM_LAST = 20'(JAM_CYCLES - 1);
   localparam logic [19:0] HIGH_MAX = 20'hF_FFFF;

   logic [2:0] raw_w;
   logic [2:0] rise_w;
   logic [2:0] jam_bits_w;

   assign raw_w = {yirmibes_raw, elli_raw, bir_raw};

   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_ch
         logic        sync1_q;
         logic        sync2_q;
         logic        stable_q;
         logic        stable_d;
         logic [15:0] db_cnt_q;
         logic [15:0] db_cnt_d;
         logic [19:0] high_cnt_q;
         logic [19:0] high_cnt_d;
         logic        jam_bit_q;
         logic        jam_bit_d;

         always_comb begin
            stable_d   = stable_q;
            db_cnt_d   = '0;
            high_cnt_d = '0;
            jam_bit_d  = jam_bit_q;
            if (sync2_q != stable_q) begin
               if (db_cnt_q == DB_LAST) begin
                  stable_d = sync2_q;
               end else begin
                  db_cnt_d = db_cnt_q + 16'd1;
               end
            end
            if (stable_q) begin
               high_cnt_d = (high_cnt_q == HIGH_MAX) ? high_cnt_q : high_cnt_q + 20'd1;
            end
            // A falling stable level wins over a jam that would be reached on the same edge.
            if (stable_q && !stable_d) begin
               jam_bit_d = 1'b0;
            end else if (stable_q && (high_cnt_q >= JAM_LAST)) begin
               jam_bit_d = 1'b1;
            end
         end

         always_ff @(posedge clk_in) begin
            if (reset) begin
               sync1_q    <= 1'b0;
               sync2_q    <= 1'b0;
               stable_q   <= 1'b0;
               db_cnt_q   <= '0;
               high_cnt_q <= '0;
               jam_bit_q  <= 1'b0;
            end else begin
               sync1_q    <= raw_w[gi];
               sync2_q    <= sync1_q;
               stable_q   <= stable_d;
               db_cnt_q   <= db_cnt_d;
               high_cnt_q <= high_cnt_d;
               jam_bit_q  <= jam_bit_d;
            end
         end

         assign rise_w[gi]     = ~stable_q & stable_d;
         assign jam_bits_w[gi] = jam_bit_q;
      end
   endgenerate

   logic [2:0] valid_rise_w;
   logic       multi_d;
   logic [2:0] coin_d;
   logic [2:0] coin_q;
   logic       multi_q;
   logic       jam_q;

   always_comb begin
      valid_rise_w = rise_w & {3{~jam_q}};
      multi_d      = (valid_rise_w[0] & valid_rise_w[1]) |
                     (valid_rise_w[0] & valid_rise_w[2]) |
                     (valid_rise_w[1] & valid_rise_w[2]);
      coin_d       = multi_d ? 3'b000 : valid_rise_w;
   end

   always_ff @(posedge clk_in) begin
      if (reset) begin
         coin_q  <= '0;
         multi_q <= 1'b0;
         jam_q   <= 1'b0;
      end else begin
         coin_q  <= coin_d;
         multi_q <= multi_d;
         jam_q   <= |jam_bits_w;
      end
   end

   assign bir       = coin_q[0];
   assign elli      = coin_q[1];
   assign yirmibes  = coin_q[2];
   assign multi_err = multi_q;
   assign jam       = jam_q;

endmodule

// File: tb/tb_coin_pulse_conditioner.sv
// Directed bench for coin_pulse_conditioner: two instances share the stimulus,
// one with the default jam threshold and one with a short threshold for jam scenarios.
module tb_coin_pulse_conditioner;

   logic clk_in = 1'b0;
   logic reset = 1'b1;
   logic bir_raw = 1'b0;
   logic elli_raw = 1'b0;
   logic yirmibes_raw = 1'b0;

   logic bir, elli, yirmibes, multi_err, jam;
   logic j_bir, j_elli, j_yirmibes, j_multi_err, j_jam;

   int errors = 0;
   int checks = 0;
   int n_bir, n_elli, n_yir, n_multi;
   int nj_bir, nj_yir, nj_multi;

   coin_pulse_conditioner #(.DEBOUNCE_CYCLES(4), .JAM_CYCLES(1000)) dut (
      .clk_in(clk_in), .reset(reset),
      .bir_raw(bir_raw), .elli_raw(elli_raw), .yirmibes_raw(yirmibes_raw),
      .bir(bir), .elli(elli), .yirmibes(yirmibes),
      .multi_err(multi_err), .jam(jam)
   );

   coin_pulse_conditioner #(.DEBOUNCE_CYCLES(4), .JAM_CYCLES(20)) dut_j (
      .clk_in(clk_in), .reset(reset),
      .bir_raw(bir_raw), .elli_raw(elli_raw), .yirmibes_raw(yirmibes_raw),
      .bir(j_bir), .elli(j_elli), .yirmibes(j_yirmibes),
      .multi_err(j_multi_err), .jam(j_jam)
   );

   always #5 clk_in = ~clk_in;

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic chk(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
      end
   endtask

   task automatic chk_int(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Advance n cycles, counting pulses seen on both instances.
   task automatic run(input int n);
      n_bir = 0; n_elli = 0; n_yir = 0; n_multi = 0;
      nj_bir = 0; nj_yir = 0; nj_multi = 0;
      for (int i = 0; i < n; i++) begin
         tick();
         n_bir    += int'(bir);
         n_elli   += int'(elli);
         n_yir    += int'(yirmibes);
         n_multi  += int'(multi_err);
         nj_bir   += int'(j_bir);
         nj_yir   += int'(j_yirmibes);
         nj_multi += int'(j_multi_err);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      bir_raw = 1'b0; elli_raw = 1'b0; yirmibes_raw = 1'b0;
      tick();
      tick();
      reset = 1'b0;
   endtask

   initial begin
      // Reset state
      do_reset();
      chk("rst_bir", bir, 1'b0);
      chk("rst_elli", elli, 1'b0);
      chk("rst_yir", yirmibes, 1'b0);
      chk("rst_multi", multi_err, 1'b0);
      chk("rst_jam", jam, 1'b0);
      $display("txn reset: outputs checked");

      // Single bir coin held: pulse only after edge 6
      bir_raw = 1'b1;
      run(5);
      chk_int("t1_early_bir", n_bir, 0);
      tick();
      chk("t1_pulse_edge6", bir, 1'b1);
      tick();
      chk("t1_pulse_one_cycle", bir, 1'b0);
      run(100);
      chk_int("t1_no_repeat", n_bir, 0);
      chk("t1_no_jam", jam, 1'b0);
      bir_raw = 1'b0;
      run(10);
      chk_int("t1_fall_no_pulse", n_bir, 0);
      $display("txn bir held: one pulse at edge 6");

      // elli toggling 3 high / 1 low, then held
      do_reset();
      for (int i = 0; i < 40; i++) begin
         elli_raw = (i % 4) != 3;
         tick();
         chk("t2_toggle_quiet", elli, 1'b0);
      end
      elli_raw = 1'b1;
      run(5);
      chk_int("t2_hold_early", n_elli, 0);
      tick();
      chk("t2_hold_pulse", elli, 1'b1);
      run(30);
      chk_int("t2_no_repeat", n_elli, 0);
      $display("txn elli bouncy: one pulse after hold");

      // Simultaneous bir and yirmibes
      do_reset();
      bir_raw = 1'b1;
      yirmibes_raw = 1'b1;
      run(5);
      chk_int("t3_early_multi", n_multi, 0);
      tick();
      chk("t3_multi", multi_err, 1'b1);
      chk("t3_bir_suppr", bir, 1'b0);
      chk("t3_yir_suppr", yirmibes, 1'b0);
      run(20);
      chk_int("t3_multi_once", n_multi, 0);
      chk_int("t3_no_bir", n_bir, 0);
      chk_int("t3_no_yir", n_yir, 0);
      $display("txn simultaneous: multi_err only");

      // Jam scenario on the short-threshold instance
      do_reset();
      yirmibes_raw = 1'b1;
      run(5);
      tick();
      chk("t4_yir_pulse", j_yirmibes, 1'b1);
      run(19);
      chk_int("t4_yir_once", nj_yir, 0);
      chk("t4_jam_not_yet", j_jam, 1'b0);
      run(3);
      chk("t4_jam_set", j_jam, 1'b1);
      bir_raw = 1'b1;
      run(12);
      chk_int("t4_bir_suppr", nj_bir, 0);
      chk_int("t4_multi_suppr", nj_multi, 0);
      bir_raw = 1'b0;
      run(10);
      chk("t4_still_jam", j_jam, 1'b1);
      yirmibes_raw = 1'b0;
      run(5);
      chk("t4_jam_hold", j_jam, 1'b1);
      run(3);
      chk("t4_jam_clear", j_jam, 1'b0);
      bir_raw = 1'b1;
      run(5);
      chk_int("t4_bir_early", nj_bir, 0);
      tick();
      chk("t4_bir_pulse", j_bir, 1'b1);
      bir_raw = 1'b0;
      run(10);
      $display("txn jam: suppressed then released");

      // Reset at edge 4 of a bir insertion
      do_reset();
      bir_raw = 1'b1;
      run(3);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("t5_rst_bir", bir, 1'b0);
      chk("t5_rst_multi", multi_err, 1'b0);
      chk("t5_rst_jam", jam, 1'b0);
      run(5);
      chk_int("t5_early", n_bir, 0);
      tick();
      chk("t5_pulse", bir, 1'b1);
      run(30);
      chk_int("t5_once", n_bir, 0);
      $display("txn reset mid-insertion: pulse after release");

      // Reset on the very edge a stable rise would occur
      do_reset();
      bir_raw = 1'b1;
      run(5);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("t6_rst_priority", bir, 1'b0);
      run(5);
      chk_int("t6_early", n_bir, 0);
      tick();
      chk("t6_pulse", bir, 1'b1);
      bir_raw = 1'b0;
      run(10);
      $display("txn reset priority over stable update");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
